// File: rtl/clk_gate_pkg.sv
// ---------------------------------------------------------------------------
// clk_gate_pkg
// Shared definitions for the clock-gating controller:
//   - cg_state_t     : per-domain gating FSM state encoding
//   - WAKE_CNT_W     : width of the wake settle counter
//   - STAT_W         : width of each gated-cycle statistics counter
//   - stat_sat_inc() : saturating increment used by the statistics counters
//                      (only used when CLK_GATE_CTRL_STATS_EN is defined)
// No ports (package).
// ---------------------------------------------------------------------------
package clk_gate_pkg;

  // Per-domain gating state. ON and DRAIN keep the clock running, OFF has
  // the clock stopped, WAKE has the clock running but not yet settled.
  typedef enum logic [1:0] {
    CG_ON    = 2'd0,
    CG_DRAIN = 2'd1,
    CG_OFF   = 2'd2,
    CG_WAKE  = 2'd3
  } cg_state_t;

  // Settle counter width; WAKE_LAT is limited to 1..15 so 4 bits suffice.
  localparam int WAKE_CNT_W = 4;

  // Width of one gated-cycle statistics counter.
  localparam int STAT_W = 32;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [STAT_W-1:0] stat_sat_inc(input logic [STAT_W-1:0] value);
    return (value == '1) ? value : value + STAT_W'(1);
  endfunction

endpackage : clk_gate_pkg

// File: rtl/clk_gate_dom_fsm.sv
// ---------------------------------------------------------------------------
// clk_gate_dom_fsm
// Gating FSM for one clock domain, including its idle counter and its wake
// settle counter. Runs the quiesce handshake before stopping the clock and
// reports ready once the restarted clock has settled.
//
// Parameters:
//   IDLE_W    width of the idle threshold / idle counter
//   WAKE_LAT  cycles from gate_en rising to ready rising (1..15)
//
// Ports:
//   clk        in   controller clock
//   rst_n      in   synchronous active-low reset
//   global_en  in   0 = never gate, keep the domain running
//   idle_cyc   in   idle cycles before gating, 0 = gating disabled
//   busy       in   domain has outstanding work
//   wake       in   wake request
//   qack       in   domain acknowledges quiesce
//   qreq       out  quiesce request (registered)
//   ready      out  clock running and settled (registered)
//   gate_en    out  enable for the gated clock cell (registered)
// ---------------------------------------------------------------------------
module clk_gate_dom_fsm
  import clk_gate_pkg::*;
#(
  parameter int IDLE_W   = 8,
  parameter int WAKE_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              global_en,
  input  logic [IDLE_W-1:0] idle_cyc,
  input  logic              busy,
  input  logic              wake,
  input  logic              qack,
  output logic              qreq,
  output logic              ready,
  output logic              gate_en
);

  localparam logic [WAKE_CNT_W-1:0] SETTLE_INIT = WAKE_CNT_W'(WAKE_LAT - 1);

  cg_state_t             state;
  cg_state_t             state_nxt;
  logic [IDLE_W-1:0]     idle_cnt;
  logic [IDLE_W-1:0]     idle_cnt_nxt;
  logic [WAKE_CNT_W-1:0] settle_cnt;
  logic [WAKE_CNT_W-1:0] settle_cnt_nxt;
  logic                  qreq_nxt;
  logic                  ready_nxt;
  logic                  gate_en_nxt;

  logic                  count_clr;
  logic                  stay_on;

  // Anything that means "do not gate" restarts the idle count.
  assign count_clr = busy | wake | ~global_en | (idle_cyc == '0);

  // Anything that must keep or bring the clock back. A global disable also
  // aborts a pending drain so a late QACK cannot stop the clock.
  assign stay_on = busy | wake | ~global_en;

  // Next-state logic together with the idle and settle counters. The idle
  // counter only advances while staying in ON; every other path leaves it
  // at zero, so leaving ON always restarts the idle window. The threshold
  // test uses >= so that lowering idle_cyc below the current count drains
  // on the very next cycle.
  always_comb begin
    state_nxt      = state;
    idle_cnt_nxt   = '0;
    settle_cnt_nxt = settle_cnt;

    unique case (state)
      CG_ON: begin
        if (!count_clr) begin
          if (idle_cnt >= (idle_cyc - IDLE_W'(1))) begin
            state_nxt = CG_DRAIN;
          end else if (idle_cnt != '1) begin
            idle_cnt_nxt = idle_cnt + IDLE_W'(1);
          end else begin
            idle_cnt_nxt = idle_cnt;
          end
        end
      end

      CG_DRAIN: begin
        // Abort wins over a simultaneous acknowledge.
        if (stay_on) begin
          state_nxt = CG_ON;
        end else if (qack) begin
          state_nxt = CG_OFF;
        end
      end

      CG_OFF: begin
        if (stay_on) begin
          state_nxt      = CG_WAKE;
          settle_cnt_nxt = SETTLE_INIT;
        end
      end

      CG_WAKE: begin
        // The domain must have released QACK before it is declared ready,
        // otherwise a stale acknowledge could be taken for a new handshake.
        if (settle_cnt != '0) begin
          settle_cnt_nxt = settle_cnt - WAKE_CNT_W'(1);
        end else if (!qack) begin
          state_nxt = CG_ON;
        end
      end

      default: begin
        state_nxt = CG_ON;
      end
    endcase
  end

  // Output decode from the next state so that the outputs can be registered
  // alongside the state and still line up with it.
  always_comb begin
    gate_en_nxt = 1'b1;
    ready_nxt   = 1'b0;
    qreq_nxt    = 1'b0;
    unique case (state_nxt)
      CG_ON: begin
        ready_nxt = 1'b1;
      end
      CG_DRAIN: begin
        ready_nxt = 1'b1;
        qreq_nxt  = 1'b1;
      end
      CG_OFF: begin
        gate_en_nxt = 1'b0;
        qreq_nxt    = 1'b1;
      end
      CG_WAKE: begin
        gate_en_nxt = 1'b1;
      end
      default: begin
        ready_nxt = 1'b1;
      end
    endcase
  end

  // State, counters and registered outputs. Reset forces the domain back to
  // a running, ready clock regardless of where the handshake was.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= CG_ON;
      idle_cnt   <= '0;
      settle_cnt <= '0;
      gate_en    <= 1'b1;
      ready      <= 1'b1;
      qreq       <= 1'b0;
    end else begin
      state      <= state_nxt;
      idle_cnt   <= idle_cnt_nxt;
      settle_cnt <= settle_cnt_nxt;
      gate_en    <= gate_en_nxt;
      ready      <= ready_nxt;
      qreq       <= qreq_nxt;
    end
  end

endmodule : clk_gate_dom_fsm

// File: rtl/clk_gate_ctrl.sv
// ---------------------------------------------------------------------------
// clk_gate_ctrl
// Per-domain clock-gating controller. Drives EN/TE of N_DOM gated clock
// cells, gating a domain after a programmable idle period and a quiesce
// handshake, and restarting it on wake with a fixed settle latency.
//
// Optional feature (macro CLK_GATE_CTRL_STATS_EN): per-domain 32-bit
// saturating counters of cycles spent gated, cleared by STAT_CLR.
//
// Parameters:
//   N_DOM     number of gated clock domains
//   IDLE_W    width of the idle threshold / counter
//   WAKE_LAT  cycles from GATE_EN rise to DOM_READY rise (1..15)
//
// Ports:
//   CLK_IN          in   free-running controller clock
//   RST_N           in   synchronous active-low reset
//   CFG_GLOBAL_EN   in   0 = never gate, all domains held on
//   CFG_IDLE_CYC    in   idle cycles before gating, 0 = gating disabled
//   SCAN_MODE       in   DFT mode, forces all test enables
//   DOM_BUSY        in   per-domain outstanding work
//   DOM_WAKE        in   per-domain wake request
//   DOM_QACK        in   per-domain quiesce acknowledge
//   DOM_QREQ        out  per-domain quiesce request
//   DOM_READY       out  per-domain clock running and settled
//   GATE_EN         out  per-domain gated cell EN
//   GATE_TE         out  per-domain gated cell TE (combinational from SCAN_MODE)
//   STAT_CLR        in   clear all statistics counters (stats build only)
//   STAT_GATED_CYC  out  N_DOM x 32-bit gated-cycle counts (stats build only)
// ---------------------------------------------------------------------------
module clk_gate_ctrl
  import clk_gate_pkg::*;
#(
  parameter int N_DOM    = 4,
  parameter int IDLE_W   = 8,
  parameter int WAKE_LAT = 2
) (
  input  logic                    CLK_IN,
  input  logic                    RST_N,
  input  logic                    CFG_GLOBAL_EN,
  input  logic [IDLE_W-1:0]       CFG_IDLE_CYC,
  input  logic                    SCAN_MODE,
  input  logic [N_DOM-1:0]        DOM_BUSY,
  input  logic [N_DOM-1:0]        DOM_WAKE,
  input  logic [N_DOM-1:0]        DOM_QACK,
  output logic [N_DOM-1:0]        DOM_QREQ,
  output logic [N_DOM-1:0]        DOM_READY,
  output logic [N_DOM-1:0]        GATE_EN,
  output logic [N_DOM-1:0]        GATE_TE
`ifdef CLK_GATE_CTRL_STATS_EN
  ,
  input  logic                    STAT_CLR,
  output logic [N_DOM*STAT_W-1:0] STAT_GATED_CYC
`endif
);

  // Scan forces every cell transparent; the gating FSMs are left untouched
  // so functional state survives a scan-mode excursion.
  assign GATE_TE = {N_DOM{SCAN_MODE}};

  // One independent FSM per domain; there is no arbitration between them.
  for (genvar d = 0; d < N_DOM; d++) begin : g_dom
    clk_gate_dom_fsm #(
      .IDLE_W   (IDLE_W),
      .WAKE_LAT (WAKE_LAT)
    ) u_fsm (
      .clk       (CLK_IN),
      .rst_n     (RST_N),
      .global_en (CFG_GLOBAL_EN),
      .idle_cyc  (CFG_IDLE_CYC),
      .busy      (DOM_BUSY[d]),
      .wake      (DOM_WAKE[d]),
      .qack      (DOM_QACK[d]),
      .qreq      (DOM_QREQ[d]),
      .ready     (DOM_READY[d]),
      .gate_en   (GATE_EN[d])
    );

`ifdef CLK_GATE_CTRL_STATS_EN
    logic [STAT_W-1:0] gated_cyc;

    // GATE_EN is low exactly while the domain sits in OFF, so it doubles as
    // the "gated this cycle" indication. Clear beats a coincident increment.
    always_ff @(posedge CLK_IN) begin
      if (!RST_N || STAT_CLR) begin
        gated_cyc <= '0;
      end else if (!GATE_EN[d]) begin
        gated_cyc <= stat_sat_inc(gated_cyc);
      end
    end

    assign STAT_GATED_CYC[d*STAT_W +: STAT_W] = gated_cyc;
`endif
  end

endmodule : clk_gate_ctrl

// File: tb/tb_clk_gate_ctrl.sv
// ---------------------------------------------------------------------------
// tb_clk_gate_ctrl
// Directed bench for clk_gate_ctrl (N_DOM=2, IDLE_W=8, WAKE_LAT=2). The
// stimulus thread pushes expected output values, tagged with the cycle they
// are due, into a queue; a monitor on the falling edge pops and compares.
// Statistics checks are included when CLK_GATE_CTRL_STATS_EN is defined.
// ---------------------------------------------------------------------------
module tb_clk_gate_ctrl;

  localparam int N_DOM = 2;
  localparam int IDLE_W = 8;

  typedef enum int {S_QREQ, S_READY, S_EN, S_TE, S_STAT0, S_STAT1} sig_e;

  typedef struct {
    int          cyc;
    string       name;
    sig_e        sig;
    logic [31:0] val;
  } exp_t;

  logic              CLK_IN = 1'b0;
  logic              RST_N;
  logic              CFG_GLOBAL_EN;
  logic [IDLE_W-1:0] CFG_IDLE_CYC;
  logic              SCAN_MODE;
  logic [N_DOM-1:0]  DOM_BUSY;
  logic [N_DOM-1:0]  DOM_WAKE;
  logic [N_DOM-1:0]  DOM_QACK;
  logic [N_DOM-1:0]  DOM_QREQ;
  logic [N_DOM-1:0]  DOM_READY;
  logic [N_DOM-1:0]  GATE_EN;
  logic [N_DOM-1:0]  GATE_TE;
`ifdef CLK_GATE_CTRL_STATS_EN
  logic              STAT_CLR;
  logic [N_DOM*32-1:0] STAT_GATED_CYC;
`endif

  exp_t exp_q[$];
  exp_t mon_e;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  clk_gate_ctrl #(
    .N_DOM    (N_DOM),
    .IDLE_W   (IDLE_W),
    .WAKE_LAT (2)
  ) dut (
    .CLK_IN         (CLK_IN),
    .RST_N          (RST_N),
    .CFG_GLOBAL_EN  (CFG_GLOBAL_EN),
    .CFG_IDLE_CYC   (CFG_IDLE_CYC),
    .SCAN_MODE      (SCAN_MODE),
    .DOM_BUSY       (DOM_BUSY),
    .DOM_WAKE       (DOM_WAKE),
    .DOM_QACK       (DOM_QACK),
    .DOM_QREQ       (DOM_QREQ),
    .DOM_READY      (DOM_READY),
    .GATE_EN        (GATE_EN),
    .GATE_TE        (GATE_TE)
`ifdef CLK_GATE_CTRL_STATS_EN
    ,
    .STAT_CLR       (STAT_CLR),
    .STAT_GATED_CYC (STAT_GATED_CYC)
`endif
  );

  always #5 CLK_IN = ~CLK_IN;

  // cyc names the interval following the n-th rising edge.
  always @(posedge CLK_IN) cyc <= cyc + 1;

  function automatic logic [31:0] getSig(input sig_e s);
    logic [31:0] r;
    r = '0;
    case (s)
      S_QREQ:  r = 32'(DOM_QREQ);
      S_READY: r = 32'(DOM_READY);
      S_EN:    r = 32'(GATE_EN);
      S_TE:    r = 32'(GATE_TE);
`ifdef CLK_GATE_CTRL_STATS_EN
      S_STAT0: r = STAT_GATED_CYC[31:0];
      S_STAT1: r = STAT_GATED_CYC[63:32];
`endif
      default: r = '0;
    endcase
    return r;
  endfunction

  task automatic applyStimulus(input logic [1:0] busy, input logic [1:0] wake,
                               input logic [1:0] qack, input logic gen,
                               input logic [7:0] idle, input logic scan);
    DOM_BUSY      = busy;
    DOM_WAKE      = wake;
    DOM_QACK      = qack;
    CFG_GLOBAL_EN = gen;
    CFG_IDLE_CYC  = idle;
    SCAN_MODE     = scan;
  endtask

  // Queue an expectation for the interval numbered 'at'.
  task automatic checkOutput(input int at, input string name, input sig_e s,
                             input logic [31:0] v);
    exp_t e;
    e.cyc  = at;
    e.name = name;
    e.sig  = s;
    e.val  = v;
    exp_q.push_back(e);
  endtask

  task automatic goTo(input int c);
    while (cyc < c) begin
      @(posedge CLK_IN);
      #1;
    end
  endtask

  // Monitor: compares every expectation due in the current interval.
  always @(negedge CLK_IN) begin
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      mon_e = exp_q.pop_front();
      vectors++;
      if (mon_e.cyc < cyc) begin
        miscompares++;
        $display("[TB] FAIL %s: due at cycle %0d, not checked until %0d", mon_e.name, mon_e.cyc, cyc);
      end else if (getSig(mon_e.sig) !== mon_e.val) begin
        miscompares++;
        $display("[TB] FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h",
                 mon_e.name, cyc, getSig(mon_e.sig), mon_e.val);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete, %0d checks pending", exp_q.size());
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int b;
    int c0;
    int c;
    int d;
    int spin;

    RST_N = 1'b0;
`ifdef CLK_GATE_CTRL_STATS_EN
    STAT_CLR = 1'b0;
`endif
    applyStimulus(2'b11, 2'b00, 2'b00, 1'b1, 8'd4, 1'b0);
    repeat (2) @(posedge CLK_IN);
    #1;
    b = cyc;

    // Reset state
    checkOutput(b, "rst_gate_en", S_EN, 32'h3);
    checkOutput(b, "rst_ready", S_READY, 32'h3);
    checkOutput(b, "rst_qreq", S_QREQ, 32'h0);
    checkOutput(b, "rst_te", S_TE, 32'h0);
    // Idle gating: threshold 4, QACK one cycle after QREQ
    checkOutput(b+3, "idle_qreq_pre", S_QREQ, 32'h0);
    checkOutput(b+4, "idle_qreq_rise", S_QREQ, 32'h1);
    checkOutput(b+5, "idle_en_drain", S_EN, 32'h3);
    checkOutput(b+6, "idle_en_off", S_EN, 32'h2);
    checkOutput(b+6, "idle_ready_off", S_READY, 32'h2);
    checkOutput(b+6, "idle_qreq_off", S_QREQ, 32'h1);
    // Wake latency: wake at b+8, QACK drops at b+9
    checkOutput(b+8, "wake_en_pre", S_EN, 32'h2);
    checkOutput(b+9, "wake_en_rise", S_EN, 32'h3);
    checkOutput(b+9, "wake_qreq_drop", S_QREQ, 32'h0);
    checkOutput(b+10, "wake_ready_settle", S_READY, 32'h2);
    checkOutput(b+11, "wake_ready_rise", S_READY, 32'h3);
    // Abort with simultaneous QACK
    checkOutput(b+15, "abort_qreq_drain", S_QREQ, 32'h1);
    checkOutput(b+15, "abort_en_drain", S_EN, 32'h3);
    checkOutput(b+16, "abort_qreq_on", S_QREQ, 32'h0);
    checkOutput(b+16, "abort_en_on", S_EN, 32'h3);
    checkOutput(b+17, "abort_ready_on", S_READY, 32'h3);
    checkOutput(b+17, "abort_qreq_stay", S_QREQ, 32'h0);

    RST_N = 1'b1;
    applyStimulus(2'b10, 2'b00, 2'b00, 1'b1, 8'd4, 1'b0);
    goTo(b+5);  applyStimulus(2'b10, 2'b00, 2'b01, 1'b1, 8'd4, 1'b0);
    goTo(b+8);  applyStimulus(2'b10, 2'b01, 2'b01, 1'b1, 8'd4, 1'b0);
    goTo(b+9);  applyStimulus(2'b10, 2'b00, 2'b00, 1'b1, 8'd4, 1'b0);
    goTo(b+15); applyStimulus(2'b11, 2'b00, 2'b01, 1'b1, 8'd4, 1'b0);
    goTo(b+17);

    // Gating disabled by a zero threshold, then by the global enable
    c0 = cyc;
    for (int k = 1; k <= 5; k++) begin
      checkOutput(c0 + k*60, "cfg0_qreq", S_QREQ, 32'h0);
      checkOutput(c0 + k*60, "cfg0_en", S_EN, 32'h3);
    end
    applyStimulus(2'b00, 2'b00, 2'b00, 1'b1, 8'd0, 1'b0);
    goTo(c0+300);
    for (int k = 1; k <= 5; k++) begin
      checkOutput(c0 + 300 + k*60, "gen0_qreq", S_QREQ, 32'h0);
      checkOutput(c0 + 300 + k*60, "gen0_en", S_EN, 32'h3);
    end
    applyStimulus(2'b00, 2'b00, 2'b00, 1'b0, 8'd4, 1'b0);
    goTo(c0+600);

    // Global-enable wake, scan, reset in OFF, QACK ignored in ON, slow QACK,
    // threshold lowered below the running count
    c = cyc;
    checkOutput(c+4, "gen_qreq", S_QREQ, 32'h1);
    checkOutput(c+8, "gen_en_off", S_EN, 32'h2);
    checkOutput(c+9, "gen_en_wake", S_EN, 32'h3);
    checkOutput(c+11, "gen_ready", S_READY, 32'h3);
    checkOutput(c+16, "gen2_qreq", S_QREQ, 32'h1);
    checkOutput(c+18, "gen2_en_off", S_EN, 32'h2);
    checkOutput(c+19, "scan_te", S_TE, 32'h3);
    checkOutput(c+19, "scan_en", S_EN, 32'h2);
    checkOutput(c+20, "scan_te_off", S_TE, 32'h0);
    checkOutput(c+20, "rst_off_en_pre", S_EN, 32'h2);
    checkOutput(c+21, "rst_off_en", S_EN, 32'h3);
    checkOutput(c+21, "rst_off_ready", S_READY, 32'h3);
    checkOutput(c+21, "rst_off_qreq", S_QREQ, 32'h0);
    checkOutput(c+24, "qack_on_ign_qreq", S_QREQ, 32'h0);
    checkOutput(c+24, "qack_on_ign_en", S_EN, 32'h3);
    checkOutput(c+25, "qack_on_ign_drain", S_QREQ, 32'h1);
    checkOutput(c+26, "qack_on_ign_off", S_EN, 32'h2);
    checkOutput(c+29, "slow_en", S_EN, 32'h3);
    checkOutput(c+33, "slow_ready_hold", S_READY, 32'h2);
    checkOutput(c+34, "slow_ready_hold2", S_READY, 32'h2);
    checkOutput(c+35, "slow_ready", S_READY, 32'h3);
    checkOutput(c+46, "thr_qreq_pre", S_QREQ, 32'h0);
    checkOutput(c+47, "thr_qreq", S_QREQ, 32'h1);
    checkOutput(c+48, "thr_abort_qreq", S_QREQ, 32'h0);
    checkOutput(c+48, "thr_abort_en", S_EN, 32'h3);

    applyStimulus(2'b10, 2'b00, 2'b00, 1'b1, 8'd4, 1'b0);
    goTo(c+5);  applyStimulus(2'b10, 2'b00, 2'b01, 1'b1, 8'd4, 1'b0);
    goTo(c+8);  applyStimulus(2'b10, 2'b00, 2'b01, 1'b0, 8'd4, 1'b0);
    goTo(c+9);  applyStimulus(2'b10, 2'b00, 2'b00, 1'b0, 8'd4, 1'b0);
    goTo(c+12); applyStimulus(2'b10, 2'b00, 2'b00, 1'b1, 8'd4, 1'b0);
    goTo(c+17); applyStimulus(2'b10, 2'b00, 2'b01, 1'b1, 8'd4, 1'b0);
    goTo(c+19); applyStimulus(2'b10, 2'b00, 2'b01, 1'b1, 8'd4, 1'b1);
    goTo(c+20); applyStimulus(2'b10, 2'b00, 2'b01, 1'b1, 8'd4, 1'b0);
    RST_N = 1'b0;
    goTo(c+21); RST_N = 1'b1;
    goTo(c+28); applyStimulus(2'b10, 2'b01, 2'b01, 1'b1, 8'd4, 1'b0);
    goTo(c+29); applyStimulus(2'b10, 2'b00, 2'b01, 1'b1, 8'd4, 1'b0);
    goTo(c+34); applyStimulus(2'b11, 2'b00, 2'b00, 1'b1, 8'd4, 1'b0);
    goTo(c+36); applyStimulus(2'b10, 2'b00, 2'b00, 1'b1, 8'd200, 1'b0);
    goTo(c+46); applyStimulus(2'b10, 2'b00, 2'b00, 1'b1, 8'd4, 1'b0);
    goTo(c+47); applyStimulus(2'b11, 2'b00, 2'b00, 1'b1, 8'd4, 1'b0);
    goTo(c+50);

`ifdef CLK_GATE_CTRL_STATS_EN
    // Ten gated cycles, then clear
    d = cyc;
    checkOutput(d+1, "stat_clr_init", S_STAT0, 32'd0);
    checkOutput(d+6, "stat_en_off", S_EN, 32'h2);
    checkOutput(d+16, "stat_10", S_STAT0, 32'd10);
    checkOutput(d+17, "stat_hold", S_STAT0, 32'd10);
    checkOutput(d+17, "stat1_zero", S_STAT1, 32'd0);
    checkOutput(d+18, "stat_pre_clr", S_STAT0, 32'd10);
    checkOutput(d+19, "stat_clr", S_STAT0, 32'd0);
    STAT_CLR = 1'b1;
    applyStimulus(2'b10, 2'b00, 2'b00, 1'b1, 8'd4, 1'b0);
    goTo(d+1);  STAT_CLR = 1'b0;
    goTo(d+5);  applyStimulus(2'b10, 2'b00, 2'b01, 1'b1, 8'd4, 1'b0);
    goTo(d+15); applyStimulus(2'b10, 2'b01, 2'b01, 1'b1, 8'd4, 1'b0);
    goTo(d+16); applyStimulus(2'b10, 2'b00, 2'b00, 1'b1, 8'd4, 1'b0);
    goTo(d+18); applyStimulus(2'b11, 2'b00, 2'b00, 1'b1, 8'd4, 1'b0);
    STAT_CLR = 1'b1;
    goTo(d+19); STAT_CLR = 1'b0;
`else
    d = cyc;
`endif

    goTo(d+21);
    spin = 0;
    while (exp_q.size() > 0 && spin < 20) begin
      @(posedge CLK_IN);
      spin++;
    end
    if (exp_q.size() > 0) begin
      $display("[TB] FAIL drain: %0d expectations never checked, expected 0", exp_q.size());
      miscompares += exp_q.size();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_clk_gate_ctrl

// File: doc/clk_gate_ctrl.md
Name: clk_gate_ctrl

Overview:
- Per-domain clock-gating controller that drives the EN/TE inputs of N GATED_CLK_CELL instances.
- Counts idle cycles per domain and runs a quiesce handshake (QREQ/QACK) before gating.
- Re-enables the clock on a wake event and reports READY after a fixed settle latency.
- Sits in the clock/power block beside the gated cells; domains are the core sub-units (e.g. FPU, vector, L2 ctrl).

Parameters:
- N_DOM, 4, number of gated clock domains
- IDLE_W, 8, width of idle threshold/counter
- WAKE_LAT, 2, cycles from GATE_EN rise to READY (1..15)

Ports:
- CLK_IN  in  1  free-running controller clock
- RST_N  in  1  synchronous active-low reset
- CFG_GLOBAL_EN  in  1  0 = never gate; all domains held ON
- CFG_IDLE_CYC  in  IDLE_W  idle cycles before gating; 0 = gating disabled
- SCAN_MODE  in  1  DFT mode
- DOM_BUSY  in  N_DOM  domain has outstanding work
- DOM_WAKE  in  N_DOM  wake request (sticky-free pulse or level)
- DOM_QACK  in  N_DOM  domain acknowledges quiesce
- DOM_QREQ  out  N_DOM  quiesce request to domain
- DOM_READY  out  N_DOM  domain clock running and settled
- GATE_EN  out  N_DOM  to GATED_CLK_CELL.EN
- GATE_TE  out  N_DOM  to GATED_CLK_CELL.TE

Behaviour:
- One clock, CLK_IN; reset synchronous, active-low, via RST_N. All outputs registered.
- Reset values: state ON, idle counter 0, GATE_EN all 1, DOM_READY all 1, DOM_QREQ all 0. GATE_TE = {N_DOM{SCAN_MODE}}; it is combinational and not reset.
- Per-domain FSM states and transitions:
  - ON: GATE_EN=1, READY=1, QREQ=0.
    - If BUSY | WAKE | !CFG_GLOBAL_EN | CFG_IDLE_CYC==0, the counter clears to 0.
    - Otherwise the counter increments, saturating at all-ones.
    - When the counter == CFG_IDLE_CYC-1 and the domain is still idle, go to DRAIN next cycle; QREQ rises on DRAIN entry.
  - DRAIN: QREQ=1, GATE_EN=1, READY=1.
    - BUSY or WAKE: abort to ON; QREQ=0 and counter=0 next cycle.
    - Else QACK: go to OFF.
    - Abort has priority over QACK when both occur in the same cycle.
  - OFF: GATE_EN=0, READY=0, QREQ held 1.
    - WAKE or BUSY: go to WAKE.
    - Deassertion of CFG_GLOBAL_EN also wakes the domain.
  - WAKE: GATE_EN=1, QREQ=0.
    - Settle counter loads WAKE_LAT-1 on entry and decrements each cycle.
    - Go to ON when it reaches 0 AND QACK==0; stay in WAKE while QACK is still high.
    - READY rises on ON entry, i.e. WAKE_LAT cycles after GATE_EN rises at minimum.
- Protocol rules:
  - QACK asserted outside DRAIN/OFF is ignored.
  - CFG_IDLE_CYC changes take effect immediately; a counter already above the new threshold triggers DRAIN next cycle.
  - SCAN_MODE does not alter the FSMs.
  - Reset mid-DRAIN or mid-OFF returns to ON with clocks enabled in the cycle after RST_N is sampled low.
- Domains are fully independent; there is no cross-domain arbitration.

Optional Feature:
- Macro: CLK_GATE_CTRL_STATS_EN.
- When defined, the block adds:
  - input STAT_CLR (1 bit);
  - output STAT_GATED_CYC (N_DOM*32 bits): one 32-bit saturating counter per domain, incrementing every cycle that domain is in OFF;
  - counters reset to 0 on reset or on STAT_CLR; if STAT_CLR and increment coincide, the counter is 0.
- When undefined, these ports and counters do not exist and behaviour is otherwise identical.

Decomposition:
- Package clk_gate_pkg holds:
  - state enum CG_ON / CG_DRAIN / CG_OFF / CG_WAKE (2-bit);
  - WAKE_CNT_W = 4;
  - STAT_W = 32.
- Sub-module clk_gate_dom_fsm is the single-domain FSM with its idle and settle counters. The top module generates N_DOM instances and the optional stats counters.

Test Plan:
- Idle gating: N_DOM=2, CFG_IDLE_CYC=4, domain 0 BUSY low from cycle 0, QACK returned 1 cycle after QREQ.
  - QREQ[0] high at cycle 4.
  - GATE_EN[0]=0 at cycle 6.
  - Domain 1, held BUSY, stays GATE_EN=1.
- Wake latency: WAKE_LAT=2, domain in OFF, WAKE pulse at cycle T, QACK dropped at T+1.
  - GATE_EN=1 at T+1.
  - READY=1 at T+3.
- Abort and priority: BUSY asserted in DRAIN together with QACK.
  - FSM returns to ON, QREQ=0, GATE_EN never drops.
- Config disable and reset: CFG_IDLE_CYC=0 or CFG_GLOBAL_EN=0, domain idle for 300 cycles.
  - No QREQ is ever issued.
  - With the domain gated, driving CFG_GLOBAL_EN low causes wake.
  - RST_N low while in OFF gives GATE_EN=1 and READY=1 next cycle.
- Slow QACK release and scan:
  - QACK held high for 5 cycles after wake: READY delayed until the cycle after QACK falls.
  - SCAN_MODE=1 sets GATE_TE to all ones without changing GATE_EN.
- Stats (CLK_GATE_CTRL_STATS_EN):
  - Domain OFF for 10 cycles gives STAT_GATED_CYC = 10.
  - STAT_CLR gives 0 next cycle.
